// File: rtl/decode_queue.sv
// Decoded-instruction queue: decodes fetched instructions on entry and buffers them for dispatch.
// Define DECODE_ILLEGAL_EN to keep unrecognised encodings as flagged entries instead of dropping them.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_ins,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_op,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [XLEN-1:0]            out_imm,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_enrd,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q;
    logic [5:0]        op_q   [DEPTH];
    logic [4:0]        rs1_q  [DEPTH];
    logic [4:0]        rs2_q  [DEPTH];
    logic [4:0]        rd_q   [DEPTH];
    logic [XLEN-1:0]   imm_q  [DEPTH];
    logic [XLEN-1:0]   pc_q   [DEPTH];
    logic              enrd_q [DEPTH];

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic              alt;
    logic [5:0]        dec_op;
    logic [2:0]        imm_kind;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_enrd;
    logic              store_ok;
    logic              do_write, do_read;

    assign opcode = in_ins[6:0];
    assign f3     = in_ins[14:12];
    assign alt    = in_ins[30];

    always_comb begin
        dec_op   = 6'd0;
        imm_kind = IMM_R;
        case (opcode)
            7'b0110111: begin dec_op = 6'd1; imm_kind = IMM_U; end
            7'b0010111: begin dec_op = 6'd2; imm_kind = IMM_U; end
            7'b1101111: begin dec_op = 6'd3; imm_kind = IMM_J; end
            7'b1100111: begin
                imm_kind = IMM_I;
                if (f3 == 3'b000) dec_op = 6'd4;
            end
            7'b1100011: begin
                imm_kind = IMM_B;
                case (f3)
                    3'b000: dec_op = 6'd5;
                    3'b001: dec_op = 6'd6;
                    3'b100: dec_op = 6'd7;
                    3'b101: dec_op = 6'd8;
                    3'b110: dec_op = 6'd9;
                    3'b111: dec_op = 6'd10;
                    default: dec_op = 6'd0;
                endcase
            end
            7'b0010011: begin
                imm_kind = IMM_I;
                case (f3)
                    3'b000: dec_op = 6'd11;
                    3'b001: dec_op = 6'd12;
                    3'b010: dec_op = 6'd13;
                    3'b011: dec_op = 6'd14;
                    3'b100: dec_op = 6'd15;
                    3'b101: dec_op = alt ? 6'd17 : 6'd16;
                    3'b110: dec_op = 6'd18;
                    default: dec_op = 6'd19;
                endcase
            end
            7'b0110011: begin
                case (f3)
                    3'b000: dec_op = alt ? 6'd20 : 6'd21;
                    3'b001: dec_op = 6'd22;
                    3'b010: dec_op = 6'd23;
                    3'b011: dec_op = 6'd24;
                    3'b100: dec_op = 6'd25;
                    3'b101: dec_op = alt ? 6'd27 : 6'd26;
                    3'b110: dec_op = 6'd28;
                    default: dec_op = 6'd29;
                endcase
            end
            7'b0000011: begin
                imm_kind = IMM_I;
                case (f3)
                    3'b000: dec_op = 6'd32;
                    3'b001: dec_op = 6'd33;
                    3'b010: dec_op = 6'd34;
                    3'b100: dec_op = 6'd35;
                    3'b101: dec_op = 6'd36;
                    default: dec_op = 6'd0;
                endcase
            end
            7'b0100011: begin
                imm_kind = IMM_S;
                case (f3)
                    3'b000: dec_op = 6'd37;
                    3'b001: dec_op = 6'd38;
                    3'b010: dec_op = 6'd39;
                    default: dec_op = 6'd0;
                endcase
            end
            default: dec_op = 6'd0;
        endcase
    end

    always_comb begin
        case (imm_kind)
            IMM_I:   imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
            IMM_S:   imm32 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
            IMM_B:   imm32 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
            IMM_U:   imm32 = {in_ins[31:12], 12'b0};
            IMM_J:   imm32 = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
            default: imm32 = 32'sd0;
        endcase
        if (dec_op == 6'd0) imm32 = 32'sd0;
        dec_imm = XLEN'(imm32);
    end

    // Branches (5..10) and stores (37..39) never write a register
    assign dec_enrd = (dec_op != 6'd0) && !(dec_op >= 6'd5 && dec_op <= 6'd10)
                      && !(dec_op >= 6'd37) && (in_ins[11:7] != 5'd0);

`ifdef DECODE_ILLEGAL_EN
    logic ill_q [DEPTH];
    assign store_ok    = 1'b1;
    assign out_illegal = ill_q[rd_ptr];
`else
    assign store_ok    = (dec_op != 6'd0);
    assign out_illegal = 1'b0;
`endif

    assign in_ready  = !rst && (count_q < CW'(DEPTH)) && en && !flush;
    assign out_valid = !rst && (count_q != '0) && en;
    assign do_write  = in_valid && in_ready && store_ok;
    assign do_read   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                rs1_q[i]  <= '0;
                rs2_q[i]  <= '0;
                rd_q[i]   <= '0;
                imm_q[i]  <= '0;
                pc_q[i]   <= '0;
                enrd_q[i] <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
                ill_q[i]  <= 1'b0;
`endif
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (en) begin
            if (do_write) begin
                op_q[wr_ptr]   <= dec_op;
                rs1_q[wr_ptr]  <= in_ins[19:15];
                rs2_q[wr_ptr]  <= in_ins[24:20];
                rd_q[wr_ptr]   <= in_ins[11:7];
                imm_q[wr_ptr]  <= dec_imm;
                pc_q[wr_ptr]   <= in_pc;
                enrd_q[wr_ptr] <= dec_enrd;
`ifdef DECODE_ILLEGAL_EN
                ill_q[wr_ptr]  <= (dec_op == 6'd0);
`endif
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(do_write) - CW'(do_read);
        end
    end

    assign out_op   = op_q[rd_ptr];
    assign out_rs1  = rs1_q[rd_ptr];
    assign out_rs2  = rs2_q[rd_ptr];
    assign out_rd   = rd_q[rd_ptr];
    assign out_imm  = imm_q[rd_ptr];
    assign out_pc   = pc_q[rd_ptr];
    assign out_enrd = enrd_q[rd_ptr];
    assign count    = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios, then random traffic against a queue model.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst, en, flush, in_valid, out_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0] in_ins;
    logic in_ready, out_valid, out_enrd, out_illegal;
    logic [5:0] out_op;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0] out_imm, out_pc;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0]      op;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] imm, pc;
        logic            enrd, ill;
    } ent_t;

    ent_t mq[$];
    int   m_wp = 0;
    int   m_rp = 0;

    decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_ins(in_ins), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_enrd(out_enrd), .out_illegal(out_illegal),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference decode from the instruction-set tables, indexed by funct3
    function automatic ent_t model_decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        ent_t e;
        int br[8] = '{5, 6, 0, 0, 7, 8, 9, 10};
        int oi[8] = '{11, 12, 13, 14, 15, 16, 18, 19};
        int rr[8] = '{21, 22, 23, 24, 25, 26, 28, 29};
        int ld[8] = '{32, 33, 34, 0, 35, 36, 0, 0};
        int st[8] = '{37, 38, 39, 0, 0, 0, 0, 0};
        int f3 = int'(ins[14:12]);
        int op = 0;
        longint v = 0;
        case (ins[6:0])
            7'h37: begin op = 1; v = longint'($signed(ins & 32'hFFFFF000)); end
            7'h17: begin op = 2; v = longint'($signed(ins & 32'hFFFFF000)); end
            7'h6F: begin
                op = 3;
                v = ins[31] * (1 << 20) + ins[19:12] * (1 << 12) + ins[20] * (1 << 11) + ins[30:21] * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            7'h67, 7'h13, 7'h03: begin
                if (ins[6:0] == 7'h67) op = (f3 == 0) ? 4 : 0;
                else if (ins[6:0] == 7'h03) op = ld[f3];
                else op = (f3 == 5 && ins[30]) ? 17 : oi[f3];
                v = ins[31:20];
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                op = br[f3];
                v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h23: begin
                op = st[f3];
                v = ins[31:25] * 32 + ins[11:7];
                if (v >= 2048) v -= 4096;
            end
            7'h33: begin
                op = rr[f3];
                if (f3 == 0 && ins[30]) op = 20;
                if (f3 == 5 && ins[30]) op = 27;
            end
            default: op = 0;
        endcase
        if (op == 0) v = 0;
        e.op   = 6'(op);
        e.rs1  = ins[19:15];
        e.rs2  = ins[24:20];
        e.rd   = ins[11:7];
        e.imm  = XLEN'(v);
        e.pc   = pc;
        e.enrd = (op != 0) && !(op >= 5 && op <= 10) && !(op >= 37 && op <= 39) && (ins[11:7] != 0);
        e.ill  = (op == 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [6:0] opc[5] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F};
        logic [31:0] r = $urandom;
        return {r[31:7], opc[$urandom_range(0, 4)]};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0] opc[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33, 7'h03, 7'h23};
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], opc[$urandom_range(0, 8)]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc);
        in_valid = v;
        in_ins   = ins;
        in_pc    = pc;
    endtask

    // One clock: check outputs against the model at the falling edge, then advance the model
    task automatic cycle();
        logic exp_ir, exp_ov, acc, deq, keep;
        ent_t e;
        @(negedge clk);
        exp_ir = !rst && (mq.size() < DEPTH) && en && !flush;
        exp_ov = !rst && (mq.size() != 0) && en;
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("count", 64'(count), 64'(mq.size()));
        check("wr_ptr", 64'(dut.wr_ptr), 64'(m_wp));
        check("rd_ptr", 64'(dut.rd_ptr), 64'(m_rp));
        if (mq.size() != 0) begin
            check("head_op", 64'(out_op), 64'(mq[0].op));
            check("head_rs1", 64'(out_rs1), 64'(mq[0].rs1));
            check("head_rs2", 64'(out_rs2), 64'(mq[0].rs2));
            check("head_rd", 64'(out_rd), 64'(mq[0].rd));
            check("head_imm", 64'(out_imm), 64'(mq[0].imm));
            check("head_pc", 64'(out_pc), 64'(mq[0].pc));
            check("head_enrd", 64'(out_enrd), 64'(mq[0].enrd));
`ifdef DECODE_ILLEGAL_EN
            check("head_illegal", 64'(out_illegal), 64'(mq[0].ill));
`endif
        end
`ifndef DECODE_ILLEGAL_EN
        check("illegal_tied", 64'(out_illegal), 64'(0));
`endif
        acc = in_valid && exp_ir;
        deq = exp_ov && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            m_wp = 0;
            m_rp = 0;
        end else begin
            if (deq) begin
                void'(mq.pop_front());
                m_rp = (m_rp + 1) % DEPTH;
            end
            if (acc) begin
                e = model_decode(in_ins, in_pc);
`ifdef DECODE_ILLEGAL_EN
                keep = 1'b1;
`else
                keep = !e.ill;
`endif
                if (keep) begin
                    mq.push_back(e);
                    m_wp = (m_wp + 1) % DEPTH;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h0000_0013, '0);
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        drive(1'b0, '0, '0);
        check("rst_op", 64'(out_op), 64'(0));
        check("rst_imm", 64'(out_imm), 64'(0));
        check("rst_pc", 64'(out_pc), 64'(0));
        check("rst_enrd", 64'(out_enrd), 64'(0));
        check("rst_illegal", 64'(out_illegal), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));

        // addi x1,x0,-1 at pc 0x100
        drive(1'b1, 32'hFFF0_0093, 32'h100);
        cycle();
        drive(1'b0, '0, '0);
        check("addi_op", 64'(out_op), 64'd11);
        check("addi_rd", 64'(out_rd), 64'd1);
        check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
        check("addi_enrd", 64'(out_enrd), 64'd1);
        check("addi_pc", 64'(out_pc), 64'h100);
        out_ready = 1'b1;
        cycle();

        // sw x1,-4(x2)
        out_ready = 1'b0;
        drive(1'b1, 32'hFE11_2E23, 32'h104);
        cycle();
        drive(1'b0, '0, '0);
        check("sw_op", 64'(out_op), 64'd39);
        check("sw_rs1", 64'(out_rs1), 64'd2);
        check("sw_rs2", 64'(out_rs2), 64'd1);
        check("sw_imm", 64'(out_imm), 64'hFFFF_FFFC);
        check("sw_enrd", 64'(out_enrd), 64'd0);
        out_ready = 1'b1;
        cycle();

        // Fill to full, try an extra push, then stream through with wrap
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, rand_legal(), XLEN'(32'h200 + 4 * i));
            cycle();
        end
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, rand_legal(), 32'h300);
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, rand_legal(), XLEN'(32'h400 + 4 * i));
            cycle();
        end
        drive(1'b0, '0, '0);
        repeat (DEPTH + 1) cycle();
        check("drained", 64'(count), 64'd0);

        // Flush with count=3 and a simultaneous accept
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_legal(), XLEN'(32'h500 + 4 * i));
            cycle();
        end
        check("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1;
        drive(1'b1, rand_legal(), 32'h600);
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_wr_ptr", 64'(dut.wr_ptr), 64'd0);
        drive(1'b1, 32'h0030_0113, 32'h604);
        cycle();
        drive(1'b0, '0, '0);
        check("post_flush_wr_ptr", 64'(dut.wr_ptr), 64'd1);
        check("post_flush_pc", 64'(out_pc), 64'h604);

        // Stall with two entries
        drive(1'b1, rand_legal(), 32'h700);
        cycle();
        en = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, rand_legal(), 32'h704);
        repeat (3) cycle();
        check("stall_count", 64'(count), 64'd2);
        check("stall_valid", 64'(out_valid), 64'd0);
        check("stall_pc", 64'(out_pc), 64'h604);
        en = 1'b1;
        drive(1'b0, '0, '0);
        cycle();
        check("resume_count", 64'(count), 64'd1);
        check("resume_pc", 64'(out_pc), 64'h700);
        cycle();

        // All-zero instruction
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h800);
        cycle();
        drive(1'b0, '0, '0);
`ifdef DECODE_ILLEGAL_EN
        check("zero_illegal", 64'(out_illegal), 64'd1);
        check("zero_op", 64'(out_op), 64'd0);
        check("zero_count", 64'(count), 64'd1);
`else
        check("zero_count", 64'(count), 64'd0);
`endif
        out_ready = 1'b1;
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(1'($urandom_range(0, 1)), rand_ins(), XLEN'($urandom));
            cycle();
        end
        rst = 1'b0; flush = 1'b0; en = 1'b1; out_ready = 1'b1;
        drive(1'b0, '0, '0);
        repeat (DEPTH + 1) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-002 The block SHALL have parameter XLEN, default 32: PC and immediate width.
REQ-003 The block SHALL have input clk, 1 bit: clock.
REQ-004 The block SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have input en, 1 bit: global stall; low freezes all state.
REQ-006 The block SHALL have input flush, 1 bit: discard all queued entries (mispredict).
REQ-007 The block SHALL have the fetch-side handshake inputs in_valid (1 bit), in_pc (XLEN bits) and in_ins (32 bits).
REQ-008 The block SHALL have output in_ready, 1 bit: entry free.
REQ-009 The block SHALL have output out_valid (1 bit) and input out_ready (1 bit): dispatch-side handshake.
REQ-010 The block SHALL have outputs out_op (6 bits) and out_rs1, out_rs2, out_rd (5 bits each): decoded head entry.
REQ-011 The block SHALL have outputs out_imm and out_pc (XLEN bits each), out_enrd (1 bit) and out_illegal (1 bit).
REQ-012 The block SHALL have output count, log2(DEPTH)+1 bits: occupied entries.

Function
REQ-013 The block SHALL accept an instruction when in_valid and in_ready are both high at a rising clk edge with en high.
REQ-014 The block SHALL decode in_ins combinationally at enqueue and store op, rs1, rs2, rd, imm, pc, enrd and illegal in the entry; raw instructions SHALL NOT be stored.
REQ-015 The block SHALL raise out_valid in the cycle after an accept into an empty queue; there SHALL be no same-cycle bypass.
REQ-016 The block SHALL drive in_ready = (count < DEPTH) && en && !flush; a full queue SHALL NOT accept, even with a same-cycle dequeue.
REQ-017 The block SHALL dequeue on out_valid && out_ready && en; a simultaneous accept and dequeue SHALL leave count unchanged.
REQ-018 The block SHALL drive out_valid = (count != 0) && en; out_* SHALL hold the head entry stable until it is dequeued.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 Flush SHALL zero both pointers and count next cycle; a same-cycle accept SHALL be dropped; flush SHALL take priority over en.
REQ-021 Immediates SHALL be sign-extended from ins[31] to XLEN for I, S, B and J types; U type SHALL be {ins[31:12], 12'b0}; R type SHALL be 0.
REQ-022 Inner op SHALL follow the team table: LUI=1, AUIPC=2, JAL=3, JALR=4, BEQ..BGEU=5..10, ADDI..ANDI=11..19, SUB=20, ADD=21, SLL..AND=22..29, LB=32, LH=33, LW=34, LBU=35, LHU=36, SB=37, SH=38, SW=39; 0 SHALL mean invalid.
REQ-023 ins[30] SHALL select SUB/ADD and SRA/SRL/SRAI/SRLI; ins[30]=1 SHALL select SUB or arithmetic shift.
REQ-024 out_enrd SHALL be 0 for branches, stores, invalid ops and rd==0, and 1 otherwise.
REQ-025 While en is low, no pointer, count or entry SHALL change.

Reset
REQ-026 rst SHALL clear pointers, count and all entries.
REQ-027 After rst, out_valid SHALL be 0, in_ready SHALL be 0 during rst, and all out_* fields SHALL be 0.
REQ-028 Reset mid-operation SHALL discard every entry, with out_valid=0 the next cycle.

Configuration
REQ-029 With DECODE_ILLEGAL_EN defined, unrecognised opcode or funct3 (including all-zero) SHALL enqueue with op=0, enrd=0 and out_illegal=1.
REQ-030 Without DECODE_ILLEGAL_EN, unrecognised encodings SHALL be dropped at enqueue (accepted, not stored) and out_illegal SHALL be tied 0.

Verification
REQ-031 The bench SHALL drive 0xFFF00093 (addi x1,x0,-1) at pc 0x100 and see out_op=11, rd=1, imm=0xFFFFFFFF, enrd=1, pc=0x100 one cycle later.
REQ-032 The bench SHALL drive 0xFE112E23 (sw x1,-4(x2)) and see op=39, rs1=2, rs2=1, imm=0xFFFFFFFC, enrd=0.
REQ-033 With DEPTH=4 and out_ready=0, four accepts SHALL give count=4 and in_ready=0; with out_ready=1 and in_valid=1, entries SHALL drain in FIFO order with count staying at most 4 and pointers wrapping.
REQ-034 With count=3 and flush asserted together with an accept, the next cycle SHALL show count=0 and out_valid=0; subsequent entries SHALL start at pointer 0.
REQ-035 With en=0 for 3 cycles while count=2, count, head fields and pointers SHALL be unchanged and out_valid=0; the queue SHALL resume when en is 1.
REQ-036 Driving 0x00000000 with DECODE_ILLEGAL_EN defined SHALL give out_illegal=1 and op=0; without the macro, count SHALL stay 0.
